// File: rtl/alu_pkg.sv
// Opcode and state types shared by alu_pipe_muldiv and its iterative unit.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SLL  = 4'b0001,
        OP_SLTU = 4'b0010,
        OP_SLT  = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111,
        OP_SUB  = 4'b1000,
        OP_MUL  = 4'b1001,
        OP_DIVU = 4'b1100,
        OP_SRA  = 4'b1101,
        OP_REMU = 4'b1110
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle multiplier (shift-add) and restoring divider; WIDTH iterations per op.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] value
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] count;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] quo, rem, divisor;

    logic [WIDTH-1:0] acc_nxt, quo_nxt, rem_nxt;
    logic [WIDTH:0]   rem_sh, diff;

    // With divisor 0 every trial subtraction succeeds, so the quotient
    // fills with ones and the remainder ends as the dividend.
    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
        rem_sh  = {rem, quo[WIDTH-1]};
        diff    = rem_sh - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            op_q    <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
        end else if (start) begin
            count   <= CNT_W'(WIDTH);
            op_q    <= op;
            acc     <= '0;
            mcand   <= a;
            mplier  <= b;
            quo     <= a;
            rem     <= '0;
            divisor <= b;
        end else if (count != '0) begin
            count  <= count - 1'b1;
            acc    <= acc_nxt;
            mcand  <= {mcand[WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            quo    <= quo_nxt;
            rem    <= rem_nxt;
        end
    end

    // Final iteration's outcome is offered combinationally so the top can register it on the last edge.
    assign done = (count == CNT_W'(1));

    always_comb begin
        case (op_q)
            OP_DIVU: value = quo_nxt;
            OP_REMU: value = rem_nxt;
            default: value = acc_nxt;
        endcase
    end

endmodule

// File: rtl/alu_pipe_muldiv.sv
// Handshaked ALU with registered result; iterative MUL/DIVU/REMU built only with ALU_MULDIV_EN.
// state | meaning: IDLE no op held | BUSY iterative op running | DONE result presented
module alu_pipe_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    alu_state_e       state;
    logic [WIDTH-1:0] simple_val;
    logic [SHAMT_W-1:0] shamt;
    logic             take_iter;
    logic             iter_done;
    logic [WIDTH-1:0] iter_value;

    assign shamt = operand_b[SHAMT_W-1:0];

    always_comb begin
        simple_val = operand_a;
        case (operation)
            OP_ADD:  simple_val = operand_a + operand_b;
            OP_SUB:  simple_val = operand_a - operand_b;
            OP_AND:  simple_val = operand_a & operand_b;
            OP_OR:   simple_val = operand_a | operand_b;
            OP_XOR:  simple_val = operand_a ^ operand_b;
            OP_SLL:  simple_val = operand_a << shamt;
            OP_SRL:  simple_val = operand_a >> shamt;
            OP_SRA:  simple_val = WIDTH'($signed(operand_a) >>> shamt);
            OP_SLT:  simple_val = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLTU: simple_val = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
            default: simple_val = operand_a;
        endcase
    end

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_valid = (state == ST_DONE);

`ifdef ALU_MULDIV_EN
    assign take_iter = is_iterative(operation);
    assign busy      = (state == ST_BUSY);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (in_valid && in_ready && take_iter),
        .op    (operation),
        .a     (operand_a),
        .b     (operand_b),
        .done  (iter_done),
        .value (iter_value)
    );
`else
    assign take_iter  = 1'b0;
    assign busy       = 1'b0;
    assign iter_done  = 1'b0;
    assign iter_value = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            case (state)
                ST_BUSY: begin
                    if (iter_done) begin
                        state  <= ST_DONE;
                        result <= iter_value;
                        zero   <= (iter_value == '0);
                    end
                end
                default: begin
                    if (in_ready) begin
                        if (!in_valid) begin
                            state <= ST_IDLE;
                        end else if (take_iter) begin
                            state <= ST_BUSY;
                        end else begin
                            state  <= ST_DONE;
                            result <= simple_val;
                            zero   <= (simple_val == '0);
                        end
                    end
                end
            endcase
        end
    end

endmodule
